// File: rtl/tlight_monitor.sv
// Passive checker for the ns/we traffic-light buses: rebuilds the controller phase from the
// lights, flags illegal combinations, order and duration errors. Interlock: TLIGHT_MON_SAFE_EN.
module tlight_monitor #(
  parameter int unsigned READY_CYCLES = 3,
  parameter int unsigned GO_CYCLES    = 15,
  parameter int unsigned STOP_CYCLES  = 1,
  parameter int unsigned CNT_W        = 5,
  parameter int unsigned CYC_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       ns,
  input  logic [1:0]       we,
  input  logic             clear,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] run_len,
  output logic             err_illegal,
  output logic             err_seq,
  output logic             err_dur,
  output logic [2:0]       err_sticky,
  output logic [CYC_W-1:0] cycles_done,
  output logic             force_red
);

  localparam logic [1:0] Red    = 2'b00;
  localparam logic [1:0] Yellow = 2'b01;
  localparam logic [1:0] Green  = 2'b10;

  localparam logic [CNT_W-1:0] ReadyLen = CNT_W'(READY_CYCLES);
  localparam logic [CNT_W-1:0] GoLen    = CNT_W'(GO_CYCLES);
  localparam logic [CNT_W-1:0] StopLen  = CNT_W'(STOP_CYCLES);
  localparam logic [CNT_W-1:0] CntMax   = '1;

  typedef enum logic [2:0] {
    StInit    = 3'd0,
    StWeReady = 3'd1,
    StWeGo    = 3'd2,
    StWeStop  = 3'd3,
    StNsReady = 3'd4,
    StNsGo    = 3'd5,
    StNsStop  = 3'd6,
    StLost    = 3'd7
  } phase_e;

  typedef enum logic [2:0] {
    ClsAllRed,
    ClsWeYellow,
    ClsWeGreen,
    ClsNsYellow,
    ClsNsGreen,
    ClsIllegal
  } cls_e;

  phase_e           phase_q, phase_d, succ_phase;
  cls_e             cls, succ_cls;
  logic             skip_q, skip_d;
  logic [3:0]       prev_q;
  logic             prev_valid_q;
  logic [CNT_W-1:0] run_len_q, run_len_d, exp_len;
  logic             changed, checked;
  logic             seq_hit, short_hit, long_hit, wrap;
  logic             err_ill_d, err_seq_d, err_dur_d;
  logic             err_ill_q, err_seq_q, err_dur_q;
  logic [2:0]       sticky_q, sticky_d;
  logic [CYC_W-1:0] cycles_q, cycles_d;

  always_comb begin
    cls = ClsIllegal;
    if (ns == Red && we == Red)         cls = ClsAllRed;
    else if (ns == Red && we == Yellow) cls = ClsWeYellow;
    else if (ns == Red && we == Green)  cls = ClsWeGreen;
    else if (ns == Yellow && we == Red) cls = ClsNsYellow;
    else if (ns == Green && we == Red)  cls = ClsNsGreen;
  end

  assign changed = !prev_valid_q || ({ns, we} != prev_q);

  always_comb begin
    if (changed)                run_len_d = CNT_W'(1);
    else if (run_len_q == CntMax) run_len_d = run_len_q;
    else                        run_len_d = run_len_q + CNT_W'(1);
  end

  // Expected successor; the yellow phases differ only in which phase precedes them.
  always_comb begin
    succ_phase = StLost;
    succ_cls   = ClsIllegal;
    exp_len    = '0;
    unique case (phase_q)
      StInit:    begin succ_phase = StWeReady; succ_cls = ClsWeYellow; end
      StWeReady: begin succ_phase = StWeGo;    succ_cls = ClsWeGreen;  exp_len = ReadyLen; end
      StWeGo:    begin succ_phase = StWeStop;  succ_cls = ClsWeYellow; exp_len = GoLen;    end
      StWeStop:  begin succ_phase = StNsReady; succ_cls = ClsNsYellow; exp_len = StopLen;  end
      StNsReady: begin succ_phase = StNsGo;    succ_cls = ClsNsGreen;  exp_len = ReadyLen; end
      StNsGo:    begin succ_phase = StNsStop;  succ_cls = ClsNsYellow; exp_len = GoLen;    end
      StNsStop:  begin succ_phase = StWeReady; succ_cls = ClsWeYellow; exp_len = StopLen;  end
      StLost:    begin succ_phase = StLost;    succ_cls = ClsIllegal;  end
    endcase
  end

  assign checked = !skip_q && (phase_q != StInit) && (phase_q != StLost);

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q      <= StInit;
      skip_q       <= 1'b0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      run_len_q    <= '0;
    end else begin
      phase_q      <= phase_d;
      skip_q       <= skip_d;
      prev_q       <= {ns, we};
      prev_valid_q <= 1'b1;
      run_len_q    <= run_len_d;
    end
  end

  // Next-state logic
  always_comb begin
    phase_d   = phase_q;
    skip_d    = skip_q;
    seq_hit   = 1'b0;
    short_hit = 1'b0;
    wrap      = 1'b0;
    if (phase_q == StLost) begin
      // The resync run is of unknown age, so it is exempt from duration checks.
      if (cls == ClsWeGreen) begin
        phase_d = StWeGo;
        skip_d  = 1'b1;
      end else if (cls == ClsNsGreen) begin
        phase_d = StNsGo;
        skip_d  = 1'b1;
      end
    end else if (cls == ClsIllegal) begin
      seq_hit = 1'b1;
      phase_d = StLost;
    end else if (phase_q == StInit && cls == ClsAllRed) begin
      phase_d = StInit;
    end else if (changed) begin
      if (cls == succ_cls) begin
        phase_d   = succ_phase;
        skip_d    = 1'b0;
        short_hit = checked && (run_len_q < exp_len);
        wrap      = (phase_q == StNsStop);
      end else begin
        seq_hit = 1'b1;
        phase_d = StLost;
      end
    end
  end

  // Output logic
  always_comb begin
    long_hit  = !changed && checked && (cls != ClsIllegal) && (run_len_d == exp_len + CNT_W'(1));
    err_ill_d = (cls == ClsIllegal);
    err_seq_d = seq_hit;
    err_dur_d = short_hit || long_hit;
    sticky_d  = (clear ? 3'b000 : sticky_q) | {err_dur_d, err_seq_d, err_ill_d};
    cycles_d  = cycles_q + CYC_W'(wrap);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      err_ill_q <= 1'b0;
      err_seq_q <= 1'b0;
      err_dur_q <= 1'b0;
      sticky_q  <= '0;
      cycles_q  <= '0;
    end else begin
      err_ill_q <= err_ill_d;
      err_seq_q <= err_seq_d;
      err_dur_q <= err_dur_d;
      sticky_q  <= sticky_d;
      cycles_q  <= cycles_d;
    end
  end

`ifdef TLIGHT_MON_SAFE_EN
  logic force_q;

  // A fresh error in the clearing cycle keeps the interlock asserted.
  always_ff @(posedge clock) begin
    if (reset)                       force_q <= 1'b0;
    else if (err_ill_d || err_seq_d) force_q <= 1'b1;
    else if (clear)                  force_q <= 1'b0;
  end

  assign force_red = force_q;
`else
  assign force_red = 1'b0;
`endif

  assign phase       = phase_q;
  assign run_len     = run_len_q;
  assign err_illegal = err_ill_q;
  assign err_seq     = err_seq_q;
  assign err_dur     = err_dur_q;
  assign err_sticky  = sticky_q;
  assign cycles_done = cycles_q;

endmodule

// File: tb/tb_tlight_monitor.sv
// Bench for tlight_monitor: directed and random light sequences, scoreboarded against a
// model that tracks the position within the ideal signal cycle.
module tb_tlight_monitor;

  localparam int ReadyN = 3;
  localparam int GoN    = 15;
  localparam int StopN  = 1;
  localparam int LenMax = 31;

`ifdef TLIGHT_MON_SAFE_EN
  localparam bit SafeEn = 1'b1;
`else
  localparam bit SafeEn = 1'b0;
`endif

  // Combination classes used by the model
  localparam int KAllRed = 0, KWeY = 1, KWeG = 2, KNsY = 3, KNsG = 4, KIll = 5;
  localparam int PosLost = 7;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  ns = 2'b00, we = 2'b00;
  logic        clear = 1'b0;
  logic [2:0]  phase;
  logic [4:0]  run_len;
  logic        err_illegal, err_seq, err_dur;
  logic [2:0]  err_sticky;
  logic [15:0] cycles_done;
  logic        force_red;

  tlight_monitor dut (
    .clock      (clock),
    .reset      (reset),
    .ns         (ns),
    .we         (we),
    .clear      (clear),
    .phase      (phase),
    .run_len    (run_len),
    .err_illegal(err_illegal),
    .err_seq    (err_seq),
    .err_dur    (err_dur),
    .err_sticky (err_sticky),
    .cycles_done(cycles_done),
    .force_red  (force_red)
  );

  always #5 clock = ~clock;

  typedef struct {
    int phase;
    int run_len;
    int ill;
    int seq;
    int dur;
    int sticky;
    int cycles;
    int frc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Ideal cycle: class expected at each position, and its required length.
  int want_cls[7] = '{KAllRed, KWeY, KWeG, KWeY, KNsY, KNsG, KNsY};
  int req_len[7]  = '{0, ReadyN, GoN, StopN, ReadyN, GoN, StopN};

  int  m_pos, m_len, m_prev, m_sticky, m_cycles;
  bit  m_pv, m_skip, m_force;

  function automatic int classify(input logic [1:0] n, input logic [1:0] w);
    if (n == 2'd0 && w == 2'd0) return KAllRed;
    if (n == 2'd0 && w == 2'd1) return KWeY;
    if (n == 2'd0 && w == 2'd2) return KWeG;
    if (n == 2'd1 && w == 2'd0) return KNsY;
    if (n == 2'd2 && w == 2'd0) return KNsG;
    return KIll;
  endfunction

  task automatic model_step(input logic [1:0] n, input logic [1:0] w, input bit clr,
                            input bit rst);
    exp_t e;
    int   c, prev_len, nxt;
    bit   chg, ill, seq, dur;
    if (rst) begin
      m_pos = 0; m_len = 0; m_prev = 0; m_sticky = 0; m_cycles = 0;
      m_pv = 0; m_skip = 0; m_force = 0;
      ill = 0; seq = 0; dur = 0;
    end else begin
      c        = classify(n, w);
      chg      = !m_pv || (m_prev != int'({n, w}));
      prev_len = m_len;
      m_len    = chg ? 1 : ((m_len + 1 > LenMax) ? LenMax : m_len + 1);
      m_prev   = int'({n, w});
      m_pv     = 1;
      ill = (c == KIll); seq = 0; dur = 0;
      if (m_pos == PosLost) begin
        if (c == KWeG) begin m_pos = 2; m_skip = 1; end
        else if (c == KNsG) begin m_pos = 5; m_skip = 1; end
      end else if (ill) begin
        seq = 1; m_pos = PosLost;
      end else if (m_pos == 0) begin
        if (c == KWeY) begin m_pos = 1; m_skip = 0; end
        else if (c != KAllRed) begin seq = 1; m_pos = PosLost; end
      end else if (!chg) begin
        if (!m_skip && m_len == req_len[m_pos] + 1) dur = 1;
      end else begin
        nxt = (m_pos % 6) + 1;
        if (c == want_cls[nxt]) begin
          if (!m_skip && prev_len < req_len[m_pos]) dur = 1;
          if (m_pos == 6) m_cycles = (m_cycles + 1) % 65536;
          m_pos = nxt; m_skip = 0;
        end else begin
          seq = 1; m_pos = PosLost;
        end
      end
      m_sticky = (clr ? 0 : m_sticky) | (int'(dur) << 2) | (int'(seq) << 1) | int'(ill);
      if (SafeEn) m_force = (ill || seq) ? 1'b1 : (clr ? 1'b0 : m_force);
    end
    e.phase = m_pos; e.run_len = m_len; e.ill = ill; e.seq = seq; e.dur = dur;
    e.sticky = m_sticky; e.cycles = m_cycles; e.frc = int'(m_force);
    sb.push_back(e);
  endtask

  task automatic drive(input logic [1:0] n, input logic [1:0] w, input bit clr, input bit rst);
    @(negedge clock);
    ns = n; we = w; clear = clr; reset = rst;
    model_step(n, w, clr, rst);
  endtask

  task automatic send(input int c, input int cnt, input bit clr);
    logic [1:0] n, w;
    n = 2'd0; w = 2'd0;
    case (c)
      KWeY: w = 2'd1;
      KWeG: w = 2'd2;
      KNsY: n = 2'd1;
      KNsG: n = 2'd2;
      KIll: begin n = 2'd2; w = 2'd2; end
      default: ;
    endcase
    for (int i = 0; i < cnt; i++) drive(n, w, clr, 1'b0);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are valid every cycle, one expected entry per sampled edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("phase", int'(phase), e.phase);
        chk("run_len", int'(run_len), e.run_len);
        chk("err_illegal", int'(err_illegal), e.ill);
        chk("err_seq", int'(err_seq), e.seq);
        chk("err_dur", int'(err_dur), e.dur);
        chk("err_sticky", int'(err_sticky), e.sticky);
        chk("cycles_done", int'(cycles_done), e.cycles);
        chk("force_red", int'(force_red), e.frc);
      end
    end
  end

  initial begin
    int d;
    drive(2'd0, 2'd0, 1'b0, 1'b1);
    drive(2'd0, 2'd0, 1'b0, 1'b1);
    // Nominal cycle
    send(KAllRed, 1, 0); send(KWeY, 3, 0); send(KWeG, 15, 0); send(KWeY, 1, 0);
    send(KNsY, 3, 0); send(KNsG, 15, 0); send(KNsY, 1, 0); send(KWeY, 3, 0);
    // Overlong green, then a short NS-yellow
    send(KWeG, 16, 0); send(KWeY, 1, 0); send(KNsY, 2, 0); send(KNsG, 15, 0);
    send(KNsY, 1, 0); send(KWeY, 3, 0); send(KWeG, 15, 0); send(KWeY, 1, 0);
    send(KNsY, 3, 0);
    // Illegal combination mid NS_GO, resync, then sticky clear
    send(KNsG, 5, 0); send(KIll, 1, 0); send(KNsG, 7, 0); send(KNsY, 1, 0);
    send(KAllRed, 1, 1); send(KNsY, 1, 1);
    send(KNsG, 3, 0); send(KNsY, 1, 0); send(KWeY, 3, 0);
    // Reset on the 8th WE-green sample, then saturate run_len in INIT
    send(KWeG, 7, 0); drive(2'd0, 2'd2, 1'b0, 1'b1);
    send(KAllRed, 40, 0);
    // Randomized cycles with jittered durations, glitches, clears and rare resets
    for (int cyc = 0; cyc < 25; cyc++) begin
      for (int p = 1; p <= 6; p++) begin
        d = req_len[p] + int'($urandom_range(0, 2)) - 1;
        if ($urandom_range(0, 3) != 0) d = req_len[p];
        if (d < 1) d = 1;
        for (int k = 0; k < d; k++) begin
          if ($urandom_range(0, 59) == 0)
            drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'b0);
          else
            send(want_cls[p], 1, ($urandom_range(0, 19) == 0));
        end
      end
      if ($urandom_range(0, 9) == 0) begin
        drive(2'd0, 2'd0, 1'b0, 1'b1);
        send(KAllRed, int'($urandom_range(1, 3)), 0);
      end
    end
    repeat (3) @(negedge clock);
    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tlight_monitor.md
Name: tlight_monitor

Overview:
- Passive observer on the `ns`/`we` light buses driven by the traffic-light controller.
- Reconstructs the controller phase from the light combination only, then checks phase order and phase durations.
- Reports illegal light combinations and counts completed signal cycles.
- Sits beside the controller in the intersection top level; also usable as a hardware checker in simulation and on FPGA.

Parameters:
- READY_CYCLES, 3, required length of WE_READY_TO_GO and NS_READY_TO_GO runs.
- GO_CYCLES, 15, required length of WE_GO and NS_GO runs.
- STOP_CYCLES, 1, required length of WE/NS_PREPARE_TO_STOP runs.
- CNT_W, 5, width of `run_len`; must hold GO_CYCLES+1.
- CYC_W, 16, width of `cycles_done`.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- ns  in  2  north-south lights, tlight_control_t.
- we  in  2  west-east lights, tlight_control_t.
- clear  in  1  clears `err_sticky`.
- phase  out  3  decoded phase: 0 INIT, 1 WE_READY, 2 WE_GO, 3 WE_STOP, 4 NS_READY, 5 NS_GO, 6 NS_STOP, 7 LOST.
- run_len  out  CNT_W  consecutive samples of the current combination; saturating.
- err_illegal  out  1  one-cycle pulse.
- err_seq  out  1  one-cycle pulse.
- err_dur  out  1  one-cycle pulse.
- err_sticky  out  3  {dur, seq, illegal}; set by pulses, held until reset or clear.
- cycles_done  out  CYC_W  completed full cycles; wraps.
- force_red  out  1  safety interlock (see Optional Feature).

Behaviour:
- Timing: `ns`/`we` sampled on every rising edge. All outputs registered; they reflect the sample taken at that edge.
- Reset: synchronous, active-high. Values: phase=0, run_len=0, all error pulses=0, err_sticky=0, cycles_done=0, force_red=0. Reset mid-operation discards all history.
- Combination classes:
  - (RED,RED) = all-red.
  - ns=RED, we=YELLOW = WE-yellow.
  - ns=RED, we=GREEN = WE-green.
  - ns=YELLOW, we=RED = NS-yellow.
  - ns=GREEN, we=RED = NS-green.
  - Anything else is illegal: an encoding outside RED/YELLOW/GREEN on either bus, or both sides non-RED.
- run_len: 1 on the first sample of a new combination; increments while the combination is unchanged; saturates at 2^CNT_W-1.
- Legal transitions:
  - INIT: all-red stays; WE-yellow -> WE_READY.
  - WE_READY -> WE-green = WE_GO.
  - WE_GO -> WE-yellow = WE_STOP.
  - WE_STOP -> NS-yellow = NS_READY.
  - NS_READY -> NS-green = NS_GO.
  - NS_GO -> NS-yellow = NS_STOP.
  - NS_STOP -> WE-yellow = WE_READY; `cycles_done` increments on the same edge.
  - Yellow phases are identical on the bus and are distinguished only by the preceding phase.
- Sequence error: any other combination change, or all-red outside INIT.
  - err_seq pulses; phase goes to LOST.
  - An illegal combination also pulses err_illegal on the same edge.
- LOST resync:
  - Stays LOST until a WE-green or NS-green sample, then enters WE_GO or NS_GO.
  - That first run is not duration-checked; later runs are checked.
  - Illegal combinations while LOST pulse err_illegal only.
- Duration check, with E = required length of the current phase:
  - Too long: err_dur pulses on the sample where run_len becomes E+1; phase is unchanged; at most one err_dur per run.
  - Too short: on a legal transition with previous run_len < E, err_dur pulses on the first sample of the new phase, and the transition is still taken.
  - INIT all-red length is never checked.
- Sticky errors: a new error pulse in the same cycle as `clear` wins, so the bit stays set.

Optional Feature:
- Macro: TLIGHT_MON_SAFE_EN.
- Defined:
  - `force_red` rises on the edge of any err_illegal or err_seq pulse.
  - It stays high until `clear` is asserted on a cycle with no new error, or until reset.
  - err_dur does not trigger `force_red`.
- Undefined: `force_red` is tied to 0; no interlock logic is synthesized.

Test Plan:
- Nominal cycle, after reset:
  - Stimulus: all-red x1, WE-yellow x3, WE-green x15, WE-yellow x1, NS-yellow x3, NS-green x15, NS-yellow x1, then WE-yellow.
  - Required: phase 0,1,2,3,4,5,6,1; no error pulses; cycles_done=1 on the final edge.
- WE-green held 16 samples: err_dur pulses once, on sample 16, with run_len=16 and phase=2; err_sticky=3'b100.
- NS-yellow only 2 samples before NS-green: err_dur on the first NS-green sample; phase=5; sequence continues with no err_seq.
- (GREEN,GREEN) during NS_GO:
  - err_illegal and err_seq pulse on the same edge; phase=7; force_red=1 if TLIGHT_MON_SAFE_EN.
  - Then NS-green x7 -> phase=5 with no err_dur; then NS-yellow -> phase=6 with no error.
- Sticky clear: `clear` in the same cycle as a new err_seq -> err_sticky[1] stays 1; `clear` alone next cycle -> err_sticky=0 and force_red=0.
- Reset asserted on the 8th WE-green sample -> next edge gives phase=0, run_len=0, cycles_done=0, all error outputs 0.
